sr_fsm_controller: RTL and testbench

- Moore-style FSM that sequences the Simple RISC Machine datapath through each instruction.
- Takes decoded opcode/op fields plus a start strobe and drives the datapath's register-file and pipeline-register controls (nsel, vsel, write, loada/b/c, loads, asel, bsel).
- Sits between the instruction decoder and the datapath. ALUop and shift go straight from the decoder to the datapath and bypass this block.

---
 rtl/sr_ctrl_pkg.sv | 65 ++++++
 rtl/sr_fsm_controller.sv | 129 ++++++++++++
 tb/tb_sr_fsm_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and encodings for the Simple RISC Machine control FSM:
// state enum, opcode/op fields, datapath select codes and the instruction classifier.
package sr_ctrl_pkg;

    typedef enum logic [3:0] {
        S_WAIT   = 4'd0,
        S_DECODE = 4'd1,
        S_WIMM   = 4'd2,
        S_GETA   = 4'd3,
        S_GETB   = 4'd4,
        S_ALU    = 4'd5,
        S_CMP    = 4'd6,
        S_WREG   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    // Instruction class captured at decode; steers the ALU-state branch and asel.
    typedef enum logic [1:0] {
        CLS_MOVI  = 2'd0,
        CLS_BIN   = 2'd1,
        CLS_CMP   = 2'd2,
        CLS_UNARY = 2'd3
    } cls_t;

    typedef struct packed {
        logic valid;
        cls_t cls;
    } instr_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOVIMM  = 2'b10;
    localparam logic [1:0] OP_MOVREG  = 2'b00;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RN    = 3'b100;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RM    = 3'b001;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    function automatic instr_t decode_instr(input logic [2:0] opc, input logic [1:0] opv);
        instr_t r;
        r = '{valid: 1'b0, cls: CLS_MOVI};
        if (opc == OPC_MOV && opv == OP_MOVIMM)      r = '{valid: 1'b1, cls: CLS_MOVI};
        else if (opc == OPC_MOV && opv == OP_MOVREG) r = '{valid: 1'b1, cls: CLS_UNARY};
        else if (opc == OPC_ALU) begin
            case (opv)
                OP_ADD:  r = '{valid: 1'b1, cls: CLS_BIN};
                OP_CMP:  r = '{valid: 1'b1, cls: CLS_CMP};
                OP_AND:  r = '{valid: 1'b1, cls: CLS_BIN};
                default: r = '{valid: 1'b1, cls: CLS_UNARY};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/sr_fsm_controller.sv
// Moore control FSM sequencing the Simple RISC Machine datapath per instruction.
// Define CTRL_ILLEGAL_TRAP_EN to trap undefined instructions in S_TRAP; otherwise they act as NOPs.
module sr_fsm_controller
    import sr_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       illegal
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    cls_t               r_cls;
    cls_t               w_next_cls;
    instr_t             w_instr;

    function automatic logic [STATE_W-1:0] enc(input state_t st);
        return STATE_W'(st);
    endfunction

    assign w_instr = decode_instr(opcode, op);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= enc(S_WAIT);
            r_cls   <= CLS_MOVI;
        end else begin
            r_state <= w_next_state;
            r_cls   <= w_next_cls;
        end
    end

    // NOTE: defaults first in every combinational block so no path leaves a signal unassigned (no latches).
    always_comb begin
        w_next_state = enc(S_WAIT);
        w_next_cls   = r_cls;
        case (r_state)
            enc(S_WAIT):   w_next_state = s ? enc(S_DECODE) : enc(S_WAIT);
            enc(S_DECODE): begin
                w_next_cls = w_instr.cls;
                if (!w_instr.valid) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_next_state = enc(S_TRAP);
`else
                    w_next_state = enc(S_WAIT);
`endif
                end else begin
                    case (w_instr.cls)
                        CLS_MOVI:  w_next_state = enc(S_WIMM);
                        CLS_UNARY: w_next_state = enc(S_GETB);
                        default:   w_next_state = enc(S_GETA);
                    endcase
                end
            end
            enc(S_WIMM):   w_next_state = enc(S_WAIT);
            enc(S_GETA):   w_next_state = enc(S_GETB);
            enc(S_GETB):   w_next_state = enc(S_ALU);
            enc(S_ALU):    w_next_state = (r_cls == CLS_CMP) ? enc(S_CMP) : enc(S_WREG);
            enc(S_CMP):    w_next_state = enc(S_WAIT);
            enc(S_WREG):   w_next_state = enc(S_WAIT);
`ifdef CTRL_ILLEGAL_TRAP_EN
            enc(S_TRAP):   w_next_state = enc(S_TRAP);
`endif
            default:       w_next_state = enc(S_WAIT);
        endcase
    end

    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_NONE;
        vsel    = VSEL_C;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        illegal = 1'b0;
        case (r_state)
            enc(S_WAIT): w = 1'b1;
            enc(S_WIMM): begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            enc(S_GETA): begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            enc(S_GETB): begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            // MOV reg and MVN pass B straight through, so A is forced to zero.
            enc(S_ALU): begin
                loadc = 1'b1;
                asel  = (r_cls == CLS_UNARY);
            end
            enc(S_CMP):  loads = 1'b1;
            enc(S_WREG): begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            enc(S_TRAP): illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sr_fsm_controller.sv
// Scoreboard bench for sr_fsm_controller: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_sr_fsm_controller;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       illegal;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } item_t;

    localparam exp_t E_WAIT  = '{w: 1'b1, default: '0};
    localparam exp_t E_ZERO  = '{default: '0};
    localparam exp_t E_WIMM  = '{nsel: 3'b100, vsel: 2'b01, write: 1'b1, default: '0};
    localparam exp_t E_GETA  = '{nsel: 3'b100, loada: 1'b1, default: '0};
    localparam exp_t E_GETB  = '{nsel: 3'b001, loadb: 1'b1, default: '0};
    localparam exp_t E_ALU   = '{loadc: 1'b1, default: '0};
    localparam exp_t E_ALU_A = '{loadc: 1'b1, asel: 1'b1, default: '0};
    localparam exp_t E_CMP   = '{loads: 1'b1, default: '0};
    localparam exp_t E_WREG  = '{nsel: 3'b010, vsel: 2'b00, write: 1'b1, default: '0};
    localparam exp_t E_TRAP  = '{illegal: 1'b1, default: '0};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
    logic [2:0] nsel;
    logic [1:0] vsel;

    item_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    done    = 1'b0;

    sr_fsm_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // One call per clock: drive inputs just after the edge, queue what that cycle must show.
    task automatic step(input logic rst, input logic sv, input logic [2:0] opc,
                        input logic [1:0] opv, input exp_t e, input string tag);
        item_t it;
        @(posedge clk);
        #1;
        reset_n = rst;
        s       = sv;
        opcode  = opc;
        op      = opv;
        it.e    = e;
        it.tag  = tag;
        q.push_back(it);
    endtask

    initial begin : monitor
        item_t it;
        exp_t  got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it  = q.pop_front();
                got = '{w: w, nsel: nsel, vsel: vsel, write: write, loada: loada,
                        loadb: loadb, loadc: loadc, loads: loads, asel: asel,
                        bsel: bsel, illegal: illegal};
                n_tests++;
                if (got !== it.e) begin
                    n_fail++;
                    $display("FAIL %s: got w,nsel,vsel,wr,la,lb,lc,ls,as,bs,il=%b want %b",
                             it.tag, got, it.e);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset state, s ignored while held in reset
        step(1'b0, 1'b1, 3'b110, 2'b10, E_WAIT, "reset");
        step(1'b1, 1'b0, 3'b110, 2'b10, E_WAIT, "idle_after_reset");

        // MOV R1,#5
        step(1'b1, 1'b1, 3'b110, 2'b10, E_WAIT, "movi_c0");
        step(1'b1, 1'b0, 3'b110, 2'b10, E_ZERO, "movi_decode");
        step(1'b1, 1'b0, 3'b110, 2'b10, E_WIMM, "movi_write");
        step(1'b1, 1'b0, 3'b110, 2'b10, E_WAIT, "movi_done");
        step(1'b1, 1'b0, 3'b110, 2'b10, E_WAIT, "movi_stay_idle");

        // ADD
        step(1'b1, 1'b1, 3'b101, 2'b00, E_WAIT, "add_c0");
        step(1'b1, 1'b0, 3'b101, 2'b00, E_ZERO, "add_decode");
        step(1'b1, 1'b0, 3'b101, 2'b00, E_GETA, "add_geta");
        step(1'b1, 1'b0, 3'b101, 2'b00, E_GETB, "add_getb");
        step(1'b1, 1'b0, 3'b101, 2'b00, E_ALU,  "add_alu");
        step(1'b1, 1'b0, 3'b101, 2'b00, E_WREG, "add_wreg");
        step(1'b1, 1'b0, 3'b101, 2'b00, E_WAIT, "add_done");

        // CMP: flags only, no register write
        step(1'b1, 1'b1, 3'b101, 2'b01, E_WAIT, "cmp_c0");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_ZERO, "cmp_decode");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_GETA, "cmp_geta");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_GETB, "cmp_getb");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_ALU,  "cmp_alu");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_CMP,  "cmp_loads");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_WAIT, "cmp_done");

        // MVN with s held high: back-to-back, s ignored mid-sequence
        step(1'b1, 1'b1, 3'b101, 2'b11, E_WAIT,  "mvn_c0");
        step(1'b1, 1'b1, 3'b101, 2'b11, E_ZERO,  "mvn_decode");
        step(1'b1, 1'b1, 3'b101, 2'b11, E_GETB,  "mvn_getb");
        step(1'b1, 1'b1, 3'b101, 2'b11, E_ALU_A, "mvn_alu");
        step(1'b1, 1'b1, 3'b101, 2'b11, E_WREG,  "mvn_wreg");
        step(1'b1, 1'b1, 3'b101, 2'b11, E_WAIT,  "mvn_done");
        step(1'b1, 1'b0, 3'b101, 2'b11, E_ZERO,  "mvn_next_decode");
        // Opcode changes after decode must not redirect the sequence
        step(1'b1, 1'b0, 3'b111, 2'b01, E_GETB,  "mvn2_getb");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_ALU_A, "mvn2_alu");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_WREG,  "mvn2_wreg");
        step(1'b1, 1'b0, 3'b101, 2'b01, E_WAIT,  "mvn2_done");

        // MOV reg
        step(1'b1, 1'b1, 3'b110, 2'b00, E_WAIT,  "movr_c0");
        step(1'b1, 1'b0, 3'b110, 2'b00, E_ZERO,  "movr_decode");
        step(1'b1, 1'b0, 3'b110, 2'b00, E_GETB,  "movr_getb");
        step(1'b1, 1'b0, 3'b110, 2'b00, E_ALU_A, "movr_alu");
        step(1'b1, 1'b0, 3'b110, 2'b00, E_WREG,  "movr_wreg");
        step(1'b1, 1'b0, 3'b110, 2'b00, E_WAIT,  "movr_done");

        // AND, aborted by reset in S_GETB, then a fresh sequence
        step(1'b1, 1'b1, 3'b101, 2'b10, E_WAIT, "and_c0");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_ZERO, "and_decode");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_GETA, "and_geta");
        step(1'b0, 1'b0, 3'b101, 2'b10, E_WAIT, "abort_in_getb");
        step(1'b1, 1'b1, 3'b101, 2'b10, E_WAIT, "fresh_c0");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_ZERO, "fresh_decode");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_GETA, "fresh_geta");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_GETB, "fresh_getb");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_ALU,  "fresh_alu");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_WREG, "fresh_wreg");
        step(1'b1, 1'b0, 3'b101, 2'b10, E_WAIT, "fresh_done");

        // Undefined opcode 111
        step(1'b1, 1'b1, 3'b111, 2'b00, E_WAIT, "ill_c0");
        step(1'b1, 1'b0, 3'b111, 2'b00, E_ZERO, "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        step(1'b1, 1'b1, 3'b111, 2'b00, E_TRAP, "trap_c2");
        step(1'b1, 1'b1, 3'b110, 2'b10, E_TRAP, "trap_hold");
        step(1'b1, 1'b0, 3'b110, 2'b10, E_TRAP, "trap_hold2");
        step(1'b0, 1'b0, 3'b110, 2'b10, E_WAIT, "trap_reset");
        step(1'b1, 1'b0, 3'b110, 2'b10, E_WAIT, "trap_released");
`else
        step(1'b1, 1'b0, 3'b111, 2'b00, E_WAIT, "nop_c2");
        step(1'b1, 1'b0, 3'b111, 2'b00, E_WAIT, "nop_stay_idle");
`endif

        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not finish by 100000, want finish");
            $fatal(1, "timeout");
        end
    end

endmodule
